// File: rtl/sprite_cmd_sched_if.sv
// ----------------------------------------------------------------------------
// sprite_cmd_sched_if
//
// Purpose: groups the host command port, the VGA timing inputs and the sprite
// command bus of sprite_cmd_sched into one bundle.
//
// Signals:
//   cmd_write    host write strobe, one command per cycle when high
//   cmd_data     32-bit sprite command word from the host
//   hcount       horizontal pixel count from the VGA timing generator
//   vcount       vertical line count from the VGA timing generator
//   bus_data     command broadcast to every sprite display component
//   bus_valid    high exactly in the cycles bus_data carries a command
//   cmd_full     command FIFO holds DEPTH entries
//   front_buf    buffer index currently being displayed
//   frame_count  number of commits issued (wrapping)
//   drop_count   number of host commands discarded (saturating)
//
// Modports:
//   master  host / timing side (drives commands and timing, observes the bus)
//   slave   scheduler side (sprite_cmd_sched)
// ----------------------------------------------------------------------------
interface sprite_cmd_sched_if;
    logic        cmd_write;
    logic [31:0] cmd_data;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] bus_data;
    logic        bus_valid;
    logic        cmd_full;
    logic        front_buf;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    modport master (
        output cmd_write, cmd_data, hcount, vcount,
        input  bus_data, bus_valid, cmd_full, front_buf, frame_count, drop_count
    );

    modport slave (
        input  cmd_write, cmd_data, hcount, vcount,
        output bus_data, bus_valid, cmd_full, front_buf, frame_count, drop_count
    );
endinterface

// File: rtl/sprite_cmd_sched.sv
// ----------------------------------------------------------------------------
// sprite_cmd_sched
//
// Purpose: buffers host sprite commands in a FIFO and broadcasts them on the
// sprite command bus. Update commands go out at one per cycle, always aimed at
// the back buffer (bit 13 forced to ~front_buf). A commit command (action
// 4'hF) is held at the FIFO head until the next vertical-blanking pulse, then
// issued, which swaps front and back buffers and counts a frame. Updates
// queued behind a commit stay queued until that commit has gone out.
//
// Parameters:
//   DEPTH    FIFO depth in entries, power of two from 4 to 64
//   VACTIVE  vcount value at which vertical blanking begins
//
// Ports:
//   clk      single clock, rising edge
//   reset    asynchronous active-high reset; empties the FIFO and clears
//            all outputs and counters
//   sif      sprite_cmd_sched_if.slave: host command port, VGA timing,
//            command bus and status outputs
//
// Optional feature:
//   SPRITE_SCHED_STATS_EN  when defined, drop_count counts discarded host
//                          writes (saturating). When undefined drop_count is
//                          tied to zero and no counter exists.
// ----------------------------------------------------------------------------
module sprite_cmd_sched #(
    parameter int DEPTH   = 16,
    parameter int VACTIVE = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_cmd_sched_if.slave    sif
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [9:0]     VBL_LINE = 10'(VACTIVE);
    localparam logic [3:0]     ACT_COMMIT = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_VBL = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    // Retarget a command word at the back buffer (the one not on screen).
    function automatic logic [31:0] to_back_buf(input logic [31:0] word,
                                                input logic        front);
        logic [31:0] r;
        r     = word;
        r[13] = ~front;
        return r;
    endfunction

    state_t          state_q,   state_d;
    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [AW:0]     count_q,   count_d;
    logic            full_q,    full_d;
    logic [31:0]     bus_data_q, bus_data_d;
    logic            bus_valid_q, bus_valid_d;
    logic            front_q,   front_d;
    logic [15:0]     frame_q,   frame_d;

    logic [31:0]     fifo_mem [DEPTH];
    logic [31:0]     head;
    logic            head_is_commit;
    logic            fifo_empty;
    logic            vblank_pulse;
    logic            push;
    logic            pop;

    assign head           = fifo_mem[rd_ptr_q];
    assign head_is_commit = (head[20:17] == ACT_COMMIT);
    assign fifo_empty     = (count_q == CNT_ZERO);
    assign vblank_pulse   = (sif.vcount == VBL_LINE) && (sif.hcount == 10'd0);
    // Full blocks the push even when the same cycle pops an entry.
    assign push           = sif.cmd_write && !full_q;

    // Scheduler FSM: next state, pop request and the next bus word.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        bus_valid_d = 1'b0;
        bus_data_d  = bus_data_q;
        front_d     = front_q;
        frame_d     = frame_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end else if (head_is_commit) begin
                    // The commit stays at the head until vblank.
                    state_d = WAIT_VBL;
                end else begin
                    pop         = 1'b1;
                    bus_valid_d = 1'b1;
                    bus_data_d  = to_back_buf(head, front_q);
                    state_d     = ISSUE;
                end
            end
            WAIT_VBL: begin
                // Only a pulse seen while waiting counts; earlier pulses are gone.
                if (vblank_pulse) begin
                    state_d = COMMIT;
                end else begin
                    state_d = WAIT_VBL;
                end
            end
            COMMIT: begin
                pop         = 1'b1;
                bus_valid_d = 1'b1;
                bus_data_d  = to_back_buf(head, front_q);
                front_d     = ~front_q;
                frame_d     = frame_q + 16'd1;
                // Anything left after popping the commit, or arriving now?
                if ((count_q > CNT_ONE) || push) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_FULL);
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sif.cmd_data;
        end
    end

    // State, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= CNT_ZERO;
            full_q      <= 1'b0;
            bus_data_q  <= 32'd0;
            bus_valid_q <= 1'b0;
            front_q     <= 1'b0;
            frame_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            bus_data_q  <= bus_data_d;
            bus_valid_q <= bus_valid_d;
            front_q     <= front_d;
            frame_q     <= frame_d;
        end
    end

`ifdef SPRITE_SCHED_STATS_EN
    logic [15:0] drop_q, drop_d;

    // Saturating count of host writes refused because the FIFO was full.
    always_comb begin
        drop_d = drop_q;
        if (sif.cmd_write && full_q && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign sif.drop_count = drop_q;
`else
    assign sif.drop_count = 16'd0;
`endif

    assign sif.bus_data    = bus_data_q;
    assign sif.bus_valid   = bus_valid_q;
    assign sif.cmd_full    = full_q;
    assign sif.front_buf   = front_q;
    assign sif.frame_count = frame_q;

endmodule

// File: tb/tb_sprite_cmd_sched.sv
// ----------------------------------------------------------------------------
// tb_sprite_cmd_sched
//
// Self-checking bench for sprite_cmd_sched. A compressed VGA timing generator
// (8 pixels per line, 525 lines, blanking at line 480) drives hcount/vcount.
// Expected bus words, with the cycle they must appear in, are queued when the
// host write is driven and popped when bus_valid is seen.
// ----------------------------------------------------------------------------
module tb_sprite_cmd_sched;

    localparam int HTOT    = 8;
    localparam int VTOT    = 525;
    localparam int FRAME   = HTOT * VTOT;
    localparam int VBL_POS = 480 * HTOT;
`ifdef SPRITE_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   pos = 0;

    exp_t sb[$];
    exp_t e;
    logic mdl_front;
    int   mdl_frames;
    int   n_checks = 0;
    int   n_fail   = 0;

    sprite_cmd_sched_if sif();

    sprite_cmd_sched #(.DEPTH(16), .VACTIVE(480)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    // Free-running timing generator and cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pos <= (pos + 1) % FRAME;
    end

    assign sif.hcount = 10'(pos % HTOT);
    assign sif.vcount = 10'(pos / HTOT);

    function automatic logic [31:0] mk_cmd(input logic [5:0] comp, input logic [3:0] act,
                                           input logic [12:0] data);
        return {comp, 5'd3, act, 3'd2, 1'b0, data};
    endfunction

    // Cycle number in which the next vblank pulse is visible.
    function automatic int next_pulse();
        return cyc + ((VBL_POS - pos + FRAME) % FRAME);
    endfunction

    // Queue the word the bus must carry; bit 13 targets the back buffer.
    task automatic expect_word(input logic [31:0] w, input int at);
        exp_t x;
        x.data     = w;
        x.data[13] = ~mdl_front;
        x.at       = at;
        sb.push_back(x);
        if (w[20:17] == 4'hF) begin
            mdl_front  = ~mdl_front;
            mdl_frames = mdl_frames + 1;
        end
    endtask

    task automatic wait_pos(input int v, input int h);
        int n;
        n = 0;
        while (!(sif.vcount == 10'(v) && sif.hcount == 10'(h)) && n < FRAME + 2) begin
            @(negedge clk);
            n++;
        end
        if (n >= FRAME + 2) begin
            n_checks++; n_fail++;
            $display("FAIL wait_pos: line %0d pixel %0d not reached", v, h);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.cmd_write = 1'b0;
        sif.cmd_data  = 32'd0;
        mdl_front = 1'b0; mdl_frames = 0; sb.delete();
        repeat (3) @(negedge clk);
        n_checks++; if (sif.bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid: got %b want 0", sif.bus_valid); end
        n_checks++; if (sif.bus_data !== 32'd0) begin n_fail++; $display("FAIL reset_bus_data: got %08h want 0", sif.bus_data); end
        n_checks++; if (sif.front_buf !== 1'b0) begin n_fail++; $display("FAIL reset_front_buf: got %b want 0", sif.front_buf); end
        n_checks++; if (sif.frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", sif.frame_count); end
        n_checks++; if (sif.drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", sif.drop_count); end
        n_checks++; if (sif.cmd_full !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_full: got %b want 0", sif.cmd_full); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        for (int k = 0; k < 8; k++) begin
            if (sif.bus_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL latency_unexpected: data %08h at cycle %0d, required idle", sif.bus_data, cyc); end
                else begin e = sb.pop_front(); if (sif.bus_data !== e.data || cyc != e.at) begin n_fail++; $display("FAIL latency_issue: got %08h at cycle %0d, required %08h at cycle %0d", sif.bus_data, cyc, e.data, e.at); end end
            end
            if (k == 0) begin
                sif.cmd_write = 1'b1; sif.cmd_data = 32'h2402_8005;
                e.data = 32'h2402_A005; e.at = cyc + 3; sb.push_back(e);
            end else begin
                sif.cmd_write = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL latency_missing: %0d words not issued, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_frame();
        wait_pos(100, 0);
        for (int k = 0; k < 3060; k++) begin
            if (sif.bus_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL frame_unexpected: data %08h at cycle %0d, required idle", sif.bus_data, cyc); end
                else begin e = sb.pop_front(); if (sif.bus_data !== e.data || cyc != e.at) begin n_fail++; $display("FAIL frame_issue: got %08h at cycle %0d, required %08h at cycle %0d", sif.bus_data, cyc, e.data, e.at); end end
            end
            if (k < 3) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'(k + 1), 4'd1, 13'(k));
                expect_word(sif.cmd_data, cyc + 3);
            end else if (k == 3) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'd2, 4'hF, 13'd0);
                expect_word(sif.cmd_data, next_pulse() + 2);
            end else begin
                sif.cmd_write = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL frame_missing: %0d words not issued, required 0", sb.size()); sb.delete(); end
        n_checks++; if (sif.front_buf !== 1'b1) begin n_fail++; $display("FAIL frame_front_buf: got %b want 1", sif.front_buf); end
        n_checks++; if (sif.frame_count !== 16'd1) begin n_fail++; $display("FAIL frame_count: got %0d want 1", sif.frame_count); end
    endtask

    task automatic test_vbl_edge();
        int pc;
        pc = 0;
        wait_pos(479, 5);
        for (int k = 0; k < FRAME + 12; k++) begin
            if (sif.bus_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL vbl_edge_unexpected: data %08h at cycle %0d, required idle", sif.bus_data, cyc); end
                else begin e = sb.pop_front(); if (sif.bus_data !== e.data || cyc != e.at) begin n_fail++; $display("FAIL vbl_edge_issue: got %08h at cycle %0d, required %08h at cycle %0d", sif.bus_data, cyc, e.data, e.at); end end
            end
            if (k == 0) begin
                pc = next_pulse();
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'd7, 4'hF, 13'h0AA);
                expect_word(sif.cmd_data, pc + 2);
            end else if (k == 1) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'd8, 4'hF, 13'h155);
                expect_word(sif.cmd_data, pc + FRAME + 2);
            end else begin
                sif.cmd_write = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL vbl_edge_missing: %0d words not issued, required 0", sb.size()); sb.delete(); end
        n_checks++; if (sif.frame_count !== 16'(mdl_frames)) begin n_fail++; $display("FAIL vbl_edge_frame_count: got %0d want %0d", sif.frame_count, mdl_frames); end
        n_checks++; if (sif.front_buf !== mdl_front) begin n_fail++; $display("FAIL vbl_edge_front_buf: got %b want %b", sif.front_buf, mdl_front); end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        seen = 0;
        wait_pos(10, 0);
        for (int k = 0; k < 8; k++) begin
            if (sif.bus_valid === 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL rst_wait_unexpected: data %08h at cycle %0d, required idle", sif.bus_data, cyc);
            end
            if (k == 0) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'd9, 4'hF, 13'd0);
            end else if (k <= 4) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'(k), 4'd3, 13'(k * 5));
            end else begin
                sif.cmd_write = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (sif.front_buf !== mdl_front) begin n_fail++; $display("FAIL rst_wait_pre_front: got %b want %b", sif.front_buf, mdl_front); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (sif.bus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_bus_valid: got %b want 0", sif.bus_valid); end
        n_checks++; if (sif.front_buf !== 1'b0) begin n_fail++; $display("FAIL rst_wait_front_buf: got %b want 0", sif.front_buf); end
        n_checks++; if (sif.frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_wait_frame_count: got %0d want 0", sif.frame_count); end
        n_checks++; if (sif.bus_data !== 32'd0) begin n_fail++; $display("FAIL rst_wait_bus_data: got %08h want 0", sif.bus_data); end
        mdl_front = 1'b0; mdl_frames = 0; sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < FRAME + 16; k++) begin
            if (sif.bus_valid === 1'b1) begin
                seen++;
                $display("FAIL rst_wait_activity: data %08h at cycle %0d, required idle", sif.bus_data, cyc);
            end
            @(negedge clk);
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_wait_quiet: %0d bus cycles seen, required 0", seen); end
        n_checks++; if (sif.front_buf !== 1'b0) begin n_fail++; $display("FAIL rst_wait_front_after: got %b want 0", sif.front_buf); end
    endtask

    task automatic test_full();
        int pc;
        pc = 0;
        wait_pos(10, 0);
        for (int k = 0; k < FRAME; k++) begin
            if (sif.bus_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL full_unexpected: data %08h at cycle %0d, required idle", sif.bus_data, cyc); end
                else begin e = sb.pop_front(); if (sif.bus_data !== e.data || cyc != e.at) begin n_fail++; $display("FAIL full_issue: got %08h at cycle %0d, required %08h at cycle %0d", sif.bus_data, cyc, e.data, e.at); end end
            end
            if (k == 20) begin
                n_checks++; if (sif.cmd_full !== 1'b1) begin n_fail++; $display("FAIL full_cmd_full: got %b want 1", sif.cmd_full); end
                n_checks++; if (sif.drop_count !== 16'(2 * STATS)) begin n_fail++; $display("FAIL full_drop_count: got %0d want %0d", sif.drop_count, 2 * STATS); end
            end
            if (k > 20 && cyc == pc + 3) begin
                n_checks++; if (sif.drop_count !== 16'(3 * STATS)) begin n_fail++; $display("FAIL full_drop_on_pop: got %0d want %0d", sif.drop_count, 3 * STATS); end
                n_checks++; if (sif.cmd_full !== 1'b0) begin n_fail++; $display("FAIL full_after_pop: got %b want 0", sif.cmd_full); end
            end
            if (k == 0) begin
                pc = next_pulse();
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'd5, 4'hF, 13'h1AB);
                expect_word(sif.cmd_data, pc + 2);
            end else if (k <= 15) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'(k), 4'd2, 13'(k * 7));
                expect_word(sif.cmd_data, pc + 2 + k);
            end else if (k <= 17) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'h3F, 4'd3, 13'h1FFF);
            end else if (cyc == pc + 1) begin
                sif.cmd_write = 1'b1; sif.cmd_data = mk_cmd(6'h3E, 4'd0, 13'h0BAD);
            end else begin
                sif.cmd_write = 1'b0;
            end
            @(negedge clk);
            if (k > 20 && cyc > pc + 25) break;
        end
        sif.cmd_write = 1'b0;
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL full_missing: %0d words not issued, required 0", sb.size()); sb.delete(); end
        n_checks++; if (sif.frame_count !== 16'(mdl_frames)) begin n_fail++; $display("FAIL full_frame_count: got %0d want %0d", sif.frame_count, mdl_frames); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_frame();
        test_vbl_edge();
        test_reset_in_wait();
        test_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
